// File: rtl/aeolus_multicycle_core.sv
// Aeolus multi-cycle core: FETCH/EXEC sequencer with a req/ack program-memory port,
// a DATA_WIDTH accumulator datapath with carry/zero flags, skip, jump and halt.
module aeolus_multicycle_core #(
   parameter  int DATA_WIDTH  = 4,
   parameter  int ADDR_WIDTH  = 8,
   localparam int INSTR_WIDTH = 4 + ADDR_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    run,
   input  logic [2*DATA_WIDTH-1:0] sw_in,
   output logic                    imem_req,
   output logic [ADDR_WIDTH-1:0]   imem_addr,
   input  logic [INSTR_WIDTH-1:0]  imem_data,
   input  logic                    imem_ack,
   output logic [DATA_WIDTH-1:0]   cpu_out,
   output logic [ADDR_WIDTH-1:0]   pc_out,
   output logic                    carry,
   output logic                    zero,
   output logic                    halted
);

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_e;

   typedef enum logic [3:0] {
      OP_NOP, OP_LDA, OP_LDB, OP_LDO, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_INV, OP_LSH, OP_RSH, OP_CLR, OP_SNZA, OP_JMP, OP_HLT
   } opcode_e;

   state_e                   state_q, state_d;
   logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
   logic [DATA_WIDTH-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d, o_q, o_d;
   logic [INSTR_WIDTH-1:0]   ir_q, ir_d;
   logic                     carry_q, carry_d, zero_q, zero_d;

   opcode_e                  opcode;
   logic [DATA_WIDTH:0]      sum, diff;
   logic                     acc_wr;

   assign opcode = opcode_e'(ir_q[INSTR_WIDTH-1:ADDR_WIDTH]);
   // Top bit of the widened difference is the borrow out of A-B.
   assign sum    = {1'b0, a_q} + {1'b0, b_q};
   assign diff   = {1'b0, a_q} - {1'b0, b_q};

   always_comb begin
      // NOTE: every next-state value defaults to its hold value first, so no path infers a latch.
      state_d  = state_q;
      pc_d     = pc_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      o_d      = o_q;
      ir_d     = ir_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      imem_req = 1'b0;
      acc_wr   = 1'b0;

      case (state_q)
         S_FETCH: begin
            // Reset must withdraw the request in the same cycle, not one edge later.
            imem_req = run & ~reset;
            if (imem_req && imem_ack) begin
               ir_d    = imem_data;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_FETCH;
            pc_d    = pc_q + 1'b1;
            case (opcode)
               OP_NOP:  ;
               OP_LDA:  a_d = sw_in[2*DATA_WIDTH-1:DATA_WIDTH];
               OP_LDB:  b_d = sw_in[DATA_WIDTH-1:0];
               OP_LDO:  o_d = acc_q;
               OP_ADD:  begin {carry_d, acc_d} = sum;                 acc_wr = 1'b1; end
               OP_SUB:  begin {carry_d, acc_d} = diff;                acc_wr = 1'b1; end
               OP_AND:  begin acc_d = a_q & b_q;                      acc_wr = 1'b1; end
               OP_OR:   begin acc_d = a_q | b_q;                      acc_wr = 1'b1; end
               OP_XOR:  begin acc_d = a_q ^ b_q;                      acc_wr = 1'b1; end
               OP_INV:  begin acc_d = ~a_q;                           acc_wr = 1'b1; end
               OP_LSH:  begin {carry_d, acc_d} = {acc_q, 1'b0};       acc_wr = 1'b1; end
               OP_RSH:  begin {acc_d, carry_d} = {1'b0, acc_q};       acc_wr = 1'b1; end
               OP_CLR:  begin acc_d = '0; carry_d = 1'b0;             acc_wr = 1'b1; end
               OP_SNZA: if (a_q != '0) pc_d = pc_q + ADDR_WIDTH'(2);
               OP_JMP:  pc_d = ir_q[ADDR_WIDTH-1:0];
               OP_HLT:  state_d = S_HALT;
            endcase
            if (acc_wr) zero_d = (acc_d == '0);
         end
         S_HALT:  ;
         default: state_d = S_FETCH;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         o_q     <= '0;
         ir_q    <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         o_q     <= o_d;
         ir_q    <= ir_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
      end
   end

   assign imem_addr = pc_q;
   assign pc_out    = pc_q;
   assign cpu_out   = o_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_aeolus_multicycle_core.sv
// Scoreboard bench for aeolus_multicycle_core: a memory responder issues fetches and pushes
// instruction-level model results; an independent monitor pops them on each handshake.
module tb_aeolus_multicycle_core;

   localparam int MOD  = 16;
   localparam int PMOD = 256;

   logic        clk = 1'b0;
   logic        reset, run, imem_req, imem_ack, carry, zero, halted;
   logic [7:0]  sw_in, imem_addr, pc_out;
   logic [11:0] imem_data;
   logic [3:0]  cpu_out;

   aeolus_multicycle_core #(.DATA_WIDTH(4), .ADDR_WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .sw_in     (sw_in),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_data (imem_data),
      .imem_ack  (imem_ack),
      .cpu_out   (cpu_out),
      .pc_out    (pc_out),
      .carry     (carry),
      .zero      (zero),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int addr; int pc; int o; int c; int z; int h;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur;
   int          pend = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [11:0] prog [256];
   logic [7:0]  sw_val;
   bit          sw_fixed, allow_drop;

   // Architectural model state
   int m_pc, m_a, m_b, m_acc, m_o, m_c, m_z, m_h;

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, expv, expv, cyc);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_a = 0; m_b = 0; m_acc = 0; m_o = 0; m_c = 0; m_z = 1; m_h = 0;
   endtask

   task automatic model_exec(input logic [11:0] ins, input logic [7:0] sw, output exp_t e);
      int op, imm, nxt, s;
      bit accw;
      op   = int'(ins[11:8]);
      imm  = int'(ins[7:0]);
      nxt  = (m_pc + 1) % PMOD;
      accw = 1'b0;
      e.addr = m_pc;
      case (op)
         1:  m_a = int'(sw) / MOD;
         2:  m_b = int'(sw) % MOD;
         3:  m_o = m_acc;
         4:  begin s = m_a + m_b; m_acc = s % MOD; m_c = (s >= MOD); accw = 1; end
         5:  begin m_acc = (m_a + MOD - m_b) % MOD; m_c = (m_a < m_b); accw = 1; end
         6:  begin m_acc = m_a & m_b; accw = 1; end
         7:  begin m_acc = m_a | m_b; accw = 1; end
         8:  begin m_acc = m_a ^ m_b; accw = 1; end
         9:  begin m_acc = MOD - 1 - m_a; accw = 1; end
         10: begin s = m_acc * 2; m_c = (s >= MOD); m_acc = s % MOD; accw = 1; end
         11: begin m_c = m_acc % 2; m_acc = m_acc / 2; accw = 1; end
         12: begin m_acc = 0; m_c = 0; accw = 1; end
         13: if (m_a != 0) nxt = (m_pc + 2) % PMOD;
         14: nxt = imm;
         15: m_h = 1;
         default: ;
      endcase
      if (accw) m_z = (m_acc == 0);
      m_pc = nxt;
      e.pc = m_pc; e.o = m_o; e.c = m_c; e.z = m_z; e.h = m_h;
   endtask

   // Monitor: a handshake pops the expected record; results are visible two negedges later.
   initial forever begin
      @(negedge clk);
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            check("post_pc",     int'(pc_out),  cur.pc);
            check("post_out",    int'(cpu_out), cur.o);
            check("post_carry",  int'(carry),   cur.c);
            check("post_zero",   int'(zero),    cur.z);
            check("post_halted", int'(halted),  cur.h);
         end
      end
      if (imem_req && imem_ack) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_fetch: handshake at addr 0x%0h with nothing issued", imem_addr);
         end else begin
            cur = exp_q.pop_front();
            check("fetch_addr", int'(imem_addr), cur.addr);
            pend = 2;
         end
      end
   end

   // Responder: serves n instructions with up to max_wait ack wait states each.
   task automatic serve(input int n, input int max_wait);
      exp_t e;
      int   w, guard;
      for (int k = 0; k < n; k++) begin
         if (m_h != 0) break;
         w     = $urandom_range(max_wait, 0);
         guard = 0;
         forever begin
            if (allow_drop && $urandom_range(4, 0) == 0) begin
               run       = 1'b0;
               imem_ack  = 1'($urandom);
               imem_data = 12'($urandom);
            end else begin
               run      = 1'b1;
               imem_ack = 1'b0;
            end
            #1;
            if (run && imem_req) begin
               if (w == 0) begin
                  if (!sw_fixed) sw_val = 8'($urandom);
                  sw_in     = sw_val;
                  imem_ack  = 1'b1;
                  imem_data = prog[imem_addr];
                  model_exec(prog[m_pc], sw_val, e);
                  exp_q.push_back(e);
                  @(posedge clk); #1;
                  imem_ack = 1'b0;
                  break;
               end
               w--;
            end
            @(posedge clk); #1;
            guard++;
            if (guard > 300) begin
               n_checks++;
               n_fail++;
               $display("FAIL serve_timeout: no fetch request from pc 0x%0h", pc_out);
               imem_ack = 1'b0;
               return;
            end
         end
      end
      imem_ack = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while ((exp_q.size() != 0 || pend != 0) && g < 50) begin
         @(posedge clk);
         g++;
      end
      if (g >= 50) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding", exp_q.size() + pend);
      end
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      run      = 1'b0;
      imem_ack = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   function automatic logic [11:0] ins(input int op, input int imm);
      return {4'(op), 8'(imm)};
   endfunction

   task automatic halt_idle(input int expect_pc);
      int reqs = 0;
      repeat (8) begin
         run      = 1'($urandom);
         imem_ack = 1'($urandom);
         @(posedge clk); #1;
         reqs += int'(imem_req);
      end
      imem_ack = 1'b0;
      check("halt_no_req", reqs, 0);
      check("halt_pc", int'(pc_out), expect_pc);
   endtask

   initial begin
      exp_t e;
      int   start, g, reqs;

      reset = 1'b1; run = 1'b1; imem_ack = 1'b0; imem_data = '0;
      sw_in = '0; sw_val = '0; sw_fixed = 1'b1; allow_drop = 1'b0;
      model_reset();
      for (int i = 0; i < 256; i++) prog[i] = ins(0, $urandom_range(255, 0));
      repeat (2) @(posedge clk);
      #1;
      check("rst_req",    int'(imem_req), 0);
      check("rst_pc",     int'(pc_out),   0);
      check("rst_out",    int'(cpu_out),  0);
      check("rst_carry",  int'(carry),    0);
      check("rst_zero",   int'(zero),     1);
      check("rst_halted", int'(halted),   0);
      reset = 1'b0;

      // Reset while a fetch is requested and the ack is arriving
      serve(2, 1);
      drain();
      check("pre_reset_pc", int'(pc_out), 2);
      run = 1'b1;
      #1;
      check("pending_req", int'(imem_req), 1);
      imem_ack  = 1'b1;
      imem_data = prog[2];
      reset     = 1'b1;
      model_reset();
      #1;
      check("midfetch_rst_req", int'(imem_req), 0);
      check("midfetch_rst_pc",  int'(pc_out),   0);
      @(posedge clk); #1;
      reset = 1'b0;
      run   = 1'b0;
      @(posedge clk); #1;
      check("late_ack_pc",  int'(pc_out),   0);
      check("late_ack_req", int'(imem_req), 0);
      imem_ack = 1'b0;

      // Zero-wait program LDA, LDB, ADD, LDO, HLT with switches 0x97
      prog[0] = ins(1, $urandom_range(255, 0));
      prog[1] = ins(2, $urandom_range(255, 0));
      prog[2] = ins(4, $urandom_range(255, 0));
      prog[3] = ins(3, $urandom_range(255, 0));
      prog[4] = ins(15, $urandom_range(255, 0));
      do_reset();
      sw_val = 8'h97;
      start  = cyc;
      serve(5, 0);
      g = 0;
      while (!halted && g < 20) begin
         @(negedge clk);
         g++;
      end
      check("halt_latency", cyc - start, 10);
      drain();
      check("prog_out",    int'(cpu_out), 0);
      check("prog_carry",  int'(carry),   1);
      check("prog_zero",   int'(zero),    1);
      check("prog_halted", int'(halted),  1);
      check("prog_pc",     int'(pc_out),  5);
      halt_idle(5);

      // Three ack wait states on a NOP at address 0, then run held low
      for (int i = 0; i < 8; i++) prog[i] = ins(0, $urandom_range(255, 0));
      do_reset();
      repeat (3) begin @(posedge clk); #1; end
      check("idle_req", int'(imem_req), 0);
      run = 1'b1;
      #1;
      check("req_rise", int'(imem_req), 1);
      start = cyc;
      repeat (3) begin @(posedge clk); #1; end
      check("req_held", int'(imem_req), 1);
      imem_ack  = 1'b1;
      imem_data = prog[0];
      model_exec(prog[m_pc], sw_val, e);
      exp_q.push_back(e);
      @(posedge clk); #1;
      imem_ack = 1'b0;
      check("exec_req", int'(imem_req), 0);
      check("exec_latency", cyc - start, 4);
      drain();
      check("wait_pc", int'(pc_out), 1);
      run  = 1'b0;
      reqs = 0;
      repeat (4) begin @(posedge clk); #1; reqs += int'(imem_req); end
      check("run_low_reqs", reqs, 0);
      check("run_low_pc", int'(pc_out), 1);
      allow_drop = 1'b1;
      serve(3, 2);
      drain();
      check("resume_pc", int'(pc_out), 4);

      // SNZA taken/not taken, JMP, and skip wrapping past 0xFF
      for (int i = 0; i < 256; i++) prog[i] = ins(0, $urandom_range(255, 0));
      prog[0]   = ins(1,  $urandom_range(255, 0));
      prog[1]   = ins(13, $urandom_range(255, 0));
      prog[2]   = ins(1,  $urandom_range(255, 0));
      prog[3]   = ins(13, $urandom_range(255, 0));
      prog[5]   = ins(14, 8'h10);
      prog[16]  = ins(14, 8'h40);
      prog[64]  = ins(14, 8'hFE);
      prog[254] = ins(13, $urandom_range(255, 0));
      do_reset();
      sw_val = 8'h05;
      serve(2, 1); drain(); check("snza_zero_pc",  int'(pc_out), 2);
      sw_val = 8'h3A;
      serve(2, 1); drain(); check("snza_skip_pc",  int'(pc_out), 5);
      serve(1, 1); drain(); check("jmp_10_pc",     int'(pc_out), 8'h10);
      serve(1, 1); drain(); check("jmp_40_pc",     int'(pc_out), 8'h40);
      serve(1, 1); drain(); check("jmp_fe_pc",     int'(pc_out), 8'hFE);
      serve(1, 1); drain(); check("snza_wrap_pc",  int'(pc_out), 0);

      // Shifts: ACC=9 via LDA/LDB/OR, then LSH, LDO, RSH, LDO
      prog[0] = ins(1, 0); prog[1] = ins(2, 0);  prog[2] = ins(7, 0);
      prog[3] = ins(10, 0); prog[4] = ins(3, 0); prog[5] = ins(11, 0); prog[6] = ins(3, 0);
      do_reset();
      sw_val = 8'h90;
      serve(4, 1); drain(); check("lsh_carry", int'(carry), 1);
      serve(1, 1); drain(); check("lsh_acc",   int'(cpu_out), 2);
      serve(1, 1); drain(); check("rsh_carry", int'(carry), 0);
      serve(1, 1); drain(); check("rsh_acc",   int'(cpu_out), 1);

      // Random programs, random switches, random wait states and run drops
      sw_fixed = 1'b0;
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 256; i++) begin
            int op;
            op = $urandom_range(15, 0);
            if (op == 15 && $urandom_range(3, 0) != 0) op = $urandom_range(14, 0);
            prog[i] = ins(op, $urandom_range(255, 0));
         end
         do_reset();
         serve(50, 3);
         drain();
         if (m_h != 0) halt_idle(m_pc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
